// File: rtl/bus_host_arbiter_pkg.sv
// Shared helpers for the host arbiter slice: index-width sizing that never collapses to zero bits.
package bus_host_arbiter_pkg;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arb_id_fifo.sv
// Host-ID FIFO recording granted-but-unanswered transactions; head visible combinationally.
// Push is ignored when full and pop when empty; the arbiter never requests either.
module bus_arb_id_fifo
  import bus_host_arbiter_pkg::*;
#(
  parameter int Depth = 2,
  parameter int Width = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [Width-1:0]             push_dat_i,
  input  logic                         pop_i,
  output logic [Width-1:0]             head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int PtrW = idx_width(Depth);
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter (with lock on stalled request) sharing one device port among NrHosts hosts.
// Zero-latency grant and response routing; dev_req_o drops while MaxOutstanding IDs are in flight.
module bus_host_arbiter
  import bus_host_arbiter_pkg::*;
#(
  parameter int NrHosts        = 2,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NrHosts-1:0]                    host_req_i,
  output logic [NrHosts-1:0]                    host_gnt_o,
  input  logic [NrHosts*AddressWidth-1:0]       host_addr_i,
  input  logic [NrHosts-1:0]                    host_we_i,
  input  logic [NrHosts*(DataWidth/8)-1:0]      host_be_i,
  input  logic [NrHosts*DataWidth-1:0]          host_wdata_i,
  output logic [NrHosts-1:0]                    host_rvalid_o,
  output logic [DataWidth-1:0]                  host_rdata_o,
  output logic [NrHosts-1:0]                    host_err_o,
  output logic                                  dev_req_o,
  output logic [AddressWidth-1:0]               dev_addr_o,
  output logic                                  dev_we_o,
  output logic [DataWidth/8-1:0]                dev_be_o,
  output logic [DataWidth-1:0]                  dev_wdata_o,
  input  logic                                  dev_gnt_i,
  input  logic                                  dev_rvalid_i,
  input  logic [DataWidth-1:0]                  dev_rdata_i,
  input  logic                                  dev_err_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                  spurious_o
);

  localparam int IdxW = idx_width(NrHosts);
  localparam int BeW  = DataWidth / 8;
  localparam int CntW = $clog2(MaxOutstanding + 1);

  logic [IdxW-1:0] prio_q, prio_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_id_q, lock_id_d;
  logic [IdxW-1:0] rr_idx, cand, winner;
  logic            rr_found, lock_live, grant, pop;
  logic [IdxW-1:0] fifo_head;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;

  always_comb begin
    rr_idx   = prio_q;
    rr_found = 1'b0;
    cand     = '0;
    for (int i = 0; i < NrHosts; i++) begin
      cand = IdxW'((int'(prio_q) + i) % NrHosts);
      if (!rr_found && host_req_i[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // A lock whose owner has withdrawn is ignored so a misbehaving host cannot deadlock the bus.
  assign lock_live = lock_q & host_req_i[lock_id_q];
  assign winner    = lock_live ? lock_id_q : rr_idx;

  // Full is taken from the registered count only; a same-cycle response cannot reopen the port.
  assign dev_req_o   = ~rst_i & (|host_req_i) & ~fifo_full;
  assign grant       = dev_req_o & dev_gnt_i;
  assign dev_addr_o  = dev_req_o ? host_addr_i[int'(winner)*AddressWidth +: AddressWidth] : '0;
  assign dev_we_o    = dev_req_o ? host_we_i[winner] : 1'b0;
  assign dev_be_o    = dev_req_o ? host_be_i[int'(winner)*BeW +: BeW] : '0;
  assign dev_wdata_o = dev_req_o ? host_wdata_i[int'(winner)*DataWidth +: DataWidth] : '0;

  assign pop           = ~rst_i & dev_rvalid_i & ~fifo_empty;
  assign spurious_o    = ~rst_i & dev_rvalid_i & fifo_empty;
  assign host_rdata_o  = rst_i ? '0 : dev_rdata_i;
  assign outstanding_o = rst_i ? '0 : fifo_count;

  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    host_err_o    = '0;
    if (grant) host_gnt_o[winner] = 1'b1;
    if (pop) begin
      host_rvalid_o[fifo_head] = 1'b1;
      host_err_o[fifo_head]    = dev_err_i;
    end
  end

  always_comb begin
    prio_d    = prio_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (grant) begin
      prio_d = (winner == IdxW'(NrHosts - 1)) ? '0 : winner + 1'b1;
      lock_d = 1'b0;
    end else if (dev_req_o) begin
      lock_d    = 1'b1;
      lock_id_d = winner;
    end else if (lock_q && !host_req_i[lock_id_q]) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q    <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      prio_q    <= prio_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  bus_arb_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_id_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (grant),
    .push_dat_i (winner),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Directed scenarios with a scoreboard: expected grants/responses/spurious pulses are queued
// by the stimulus thread and consumed by an independent monitor at each falling edge.
module tb_bus_host_arbiter;

  localparam int NH = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MO = 2;

  logic               clk = 1'b0;
  logic               rst_i;
  logic [NH-1:0]      host_req_i;
  logic [NH-1:0]      host_gnt_o;
  logic [NH*AW-1:0]   host_addr_i;
  logic [NH-1:0]      host_we_i;
  logic [NH*DW/8-1:0] host_be_i;
  logic [NH*DW-1:0]   host_wdata_i;
  logic [NH-1:0]      host_rvalid_o;
  logic [DW-1:0]      host_rdata_o;
  logic [NH-1:0]      host_err_o;
  logic               dev_req_o;
  logic [AW-1:0]      dev_addr_o;
  logic               dev_we_o;
  logic [DW/8-1:0]    dev_be_o;
  logic [DW-1:0]      dev_wdata_o;
  logic               dev_gnt_i;
  logic               dev_rvalid_i;
  logic [DW-1:0]      dev_rdata_i;
  logic               dev_err_i;
  logic [1:0]         outstanding_o;
  logic               spurious_o;

  always #5 clk = ~clk;

  bus_host_arbiter #(
    .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o),
    .host_addr_i(host_addr_i), .host_we_i(host_we_i), .host_be_i(host_be_i),
    .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .dev_req_o(dev_req_o), .dev_addr_o(dev_addr_o), .dev_we_o(dev_we_o),
    .dev_be_o(dev_be_o), .dev_wdata_o(dev_wdata_o),
    .dev_gnt_i(dev_gnt_i), .dev_rvalid_i(dev_rvalid_i), .dev_rdata_i(dev_rdata_i),
    .dev_err_i(dev_err_i),
    .outstanding_o(outstanding_o), .spurious_o(spurious_o)
  );

  typedef struct { int id; logic [31:0] addr; logic we; } gexp_t;
  typedef struct { int id; logic err; logic [31:0] data; } rexp_t;

  gexp_t q_gnt[$];
  rexp_t q_rsp[$];
  bit    q_spur[$];
  int    n_checks = 0;
  int    n_errs   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                       input logic er, input logic [31:0] rd);
    host_req_i   = req;
    dev_gnt_i    = gnt;
    dev_rvalid_i = rv;
    dev_err_i    = er;
    dev_rdata_i  = rd;
  endtask

  task automatic exp_g(input int id);
    gexp_t g;
    g.id   = id;
    g.addr = (id == 0) ? 32'h1000_0000 : 32'h2000_0000;
    g.we   = (id == 1);
    q_gnt.push_back(g);
  endtask

  task automatic exp_r(input int id, input logic err, input logic [31:0] d);
    rexp_t r;
    r.id = id; r.err = err; r.data = d;
    q_rsp.push_back(r);
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    to_neg();
    to_next();
  endtask

  // Monitor: every presented grant / response / spurious pulse must match the queue head.
  initial begin
    gexp_t g;
    rexp_t r;
    forever begin
      @(negedge clk);
      if (host_gnt_o != '0) begin
        if (q_gnt.size() == 0) chk("unexpected_gnt", 64'(host_gnt_o), 64'd0);
        else begin
          g = q_gnt.pop_front();
          chk("gnt_onehot", 64'(host_gnt_o), 64'd1 << g.id);
          chk("dev_addr", 64'(dev_addr_o), 64'(g.addr));
          chk("dev_we", 64'(dev_we_o), 64'(g.we));
        end
      end
      if (host_rvalid_o != '0) begin
        if (q_rsp.size() == 0) chk("unexpected_rvalid", 64'(host_rvalid_o), 64'd0);
        else begin
          r = q_rsp.pop_front();
          chk("rvalid_onehot", 64'(host_rvalid_o), 64'd1 << r.id);
          chk("rsp_err", 64'(host_err_o), r.err ? (64'd1 << r.id) : 64'd0);
          chk("rsp_data", 64'(host_rdata_o), 64'(r.data));
        end
      end
      if (spurious_o) begin
        if (q_spur.size() == 0) chk("unexpected_spurious", 64'd1, 64'd0);
        else begin
          void'(q_spur.pop_front());
          chk("spurious_no_rvalid", 64'(host_rvalid_o), 64'd0);
        end
      end
    end
  end

  initial begin
    host_addr_i  = {32'h2000_0000, 32'h1000_0000};
    host_we_i    = 2'b10;
    host_be_i    = 8'h3F;
    host_wdata_i = {32'hBBBB_0001, 32'hAAAA_0000};
    rst_i = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset state
    to_neg();
    chk("rst_gnt", 64'(host_gnt_o), 64'd0);
    chk("rst_rvalid", 64'(host_rvalid_o), 64'd0);
    chk("rst_err", 64'(host_err_o), 64'd0);
    chk("rst_dev_req", 64'(dev_req_o), 64'd0);
    chk("rst_spurious", 64'(spurious_o), 64'd0);
    chk("rst_outstanding", 64'(outstanding_o), 64'd0);
    to_next();
    rst_i = 1'b0;

    // Both hosts request, single-cycle responses: grants alternate, responses follow
    drive(2'b11, 1'b1, 1'b0, 1'b0, 32'h0);          exp_g(0); cyc();
    drive(2'b11, 1'b1, 1'b1, 1'b0, 32'hA1); exp_g(1); exp_r(0, 1'b0, 32'hA1); cyc();
    drive(2'b11, 1'b1, 1'b1, 1'b0, 32'hA2); exp_g(0); exp_r(1, 1'b0, 32'hA2); cyc();
    drive(2'b11, 1'b1, 1'b1, 1'b0, 32'hA3); exp_g(1); exp_r(0, 1'b0, 32'hA3); cyc();
    drive(2'b00, 1'b0, 1'b1, 1'b1, 32'hA4);           exp_r(1, 1'b1, 32'hA4);
    to_neg();
    chk("idle_dev_req", 64'(dev_req_o), 64'd0);
    chk("idle_dev_addr", 64'(dev_addr_o), 64'd0);
    to_next();
    drive(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    to_neg(); chk("drained_outstanding", 64'(outstanding_o), 64'd0); to_next();

    // Lock: host 1 stalls three cycles, then host 0 joins; host 1 still wins
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 1'b0, 1'b0, 1'b0, 32'h0);
      to_neg();
      chk("stall_dev_req", 64'(dev_req_o), 64'd1);
      chk("stall_addr", 64'(dev_addr_o), 64'h2000_0000);
      to_next();
    end
    drive(2'b11, 1'b0, 1'b0, 1'b0, 32'h0);
    to_neg(); chk("locked_addr", 64'(dev_addr_o), 64'h2000_0000); to_next();
    drive(2'b11, 1'b1, 1'b0, 1'b0, 32'h0); exp_g(1); cyc();
    drive(2'b00, 1'b0, 1'b1, 1'b0, 32'hB1); exp_r(1, 1'b0, 32'hB1); cyc();

    // Outstanding limit: two grants, then a same-cycle response must not reopen the port
    drive(2'b01, 1'b1, 1'b0, 1'b0, 32'h0); exp_g(0); cyc();
    drive(2'b01, 1'b1, 1'b0, 1'b0, 32'h0); exp_g(0); cyc();
    drive(2'b01, 1'b1, 1'b1, 1'b0, 32'hC1); exp_r(0, 1'b0, 32'hC1);
    to_neg();
    chk("full_dev_req", 64'(dev_req_o), 64'd0);
    chk("full_outstanding", 64'(outstanding_o), 64'd2);
    to_next();
    drive(2'b01, 1'b1, 1'b0, 1'b0, 32'h0); exp_g(0);
    to_neg(); chk("reopen_dev_req", 64'(dev_req_o), 64'd1); to_next();
    drive(2'b00, 1'b0, 1'b1, 1'b0, 32'hC2); exp_r(0, 1'b0, 32'hC2); cyc();
    drive(2'b00, 1'b0, 1'b1, 1'b0, 32'hC3); exp_r(0, 1'b0, 32'hC3); cyc();

    // Grant to host 0 while an earlier host 1 transaction completes
    drive(2'b10, 1'b1, 1'b0, 1'b0, 32'h0); exp_g(1); cyc();
    drive(2'b01, 1'b1, 1'b1, 1'b1, 32'hD1); exp_g(0); exp_r(1, 1'b1, 32'hD1);
    to_neg(); chk("pushpop_outstanding_pre", 64'(outstanding_o), 64'd1); to_next();
    drive(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    to_neg(); chk("pushpop_outstanding_post", 64'(outstanding_o), 64'd1); to_next();
    drive(2'b00, 1'b0, 1'b1, 1'b0, 32'hD2); exp_r(0, 1'b0, 32'hD2); cyc();

    // Response with nothing outstanding
    drive(2'b00, 1'b0, 1'b1, 1'b0, 32'hE1); q_spur.push_back(1'b1);
    to_neg(); chk("spur_rvalid", 64'(host_rvalid_o), 64'd0); to_next();
    drive(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    to_neg(); chk("spur_single_pulse", 64'(spurious_o), 64'd0); to_next();

    // Reset with two outstanding; later response is spurious and priority restarts at 0
    drive(2'b11, 1'b1, 1'b0, 1'b0, 32'h0); exp_g(1); cyc();
    drive(2'b11, 1'b1, 1'b0, 1'b0, 32'h0); exp_g(0); cyc();
    rst_i = 1'b1;
    drive(2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
    to_neg(); chk("midrst_dev_req", 64'(dev_req_o), 64'd0); to_next();
    rst_i = 1'b0;
    drive(2'b00, 1'b0, 1'b1, 1'b0, 32'hF1); q_spur.push_back(1'b1);
    to_neg(); chk("postrst_outstanding", 64'(outstanding_o), 64'd0); to_next();
    drive(2'b11, 1'b1, 1'b0, 1'b0, 32'h0); exp_g(0); cyc();
    drive(2'b00, 1'b0, 1'b1, 1'b0, 32'hF2); exp_r(0, 1'b0, 32'hF2); cyc();

    drive(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    to_neg();
    chk("gnt_queue_left", 64'(q_gnt.size()), 64'd0);
    chk("rsp_queue_left", 64'(q_rsp.size()), 64'd0);
    chk("spur_queue_left", 64'(q_spur.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_host_arbiter.md
BUS_HOST_ARBITER -- requirements
Module: bus_host_arbiter

Interface
REQ-001 SHALL have parameter NrHosts, default 2, number of requesting hosts (2..8).
REQ-002 SHALL have parameter DataWidth, default 32, data bus width.
REQ-003 SHALL have parameter AddressWidth, default 32, address bus width.
REQ-004 SHALL have parameter MaxOutstanding, default 2, number of granted-but-unanswered transactions allowed (1..8).
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports as listed below.
REQ-006 clk_i  in  1  system clock; all state updates on its rising edge.
REQ-007 rst_i  in  1  synchronous reset, active-high.
REQ-008 host_req_i  in  NrHosts  per-host request.
REQ-009 host_gnt_o  out  NrHosts  per-host grant, one-hot or zero.
REQ-010 host_addr_i / host_we_i / host_be_i / host_wdata_i  in  NrHosts x (AddressWidth / 1 / DataWidth/8 / DataWidth)  per-host request payload.
REQ-011 host_rvalid_o  out  NrHosts  per-host response valid, one-hot or zero.
REQ-012 host_rdata_o  out  DataWidth  response data, broadcast to all hosts.
REQ-013 host_err_o  out  NrHosts  per-host response error, qualified by host_rvalid_o.
REQ-014 dev_req_o / dev_addr_o / dev_we_o / dev_be_o / dev_wdata_o  out  1 / AddressWidth / 1 / DataWidth/8 / DataWidth  shared downstream request.
REQ-015 dev_gnt_i / dev_rvalid_i / dev_rdata_i / dev_err_i  in  1 / 1 / DataWidth / 1  downstream grant and response.
REQ-016 outstanding_o  out  $clog2(MaxOutstanding+1)  current outstanding count.
REQ-017 spurious_o  out  1  single-cycle pulse on a dev_rvalid_i arriving with zero outstanding.

Function
REQ-018 Selection SHALL be round-robin: the winner is the first requesting host at or after index prio_q, wrapping modulo NrHosts.
REQ-019 While locked (see REQ-020), the winner SHALL be lock_id_q regardless of the other requests.
REQ-020 If dev_req_o=1 and dev_gnt_i=0, the arbiter SHALL set lock_id_q=winner and stay locked until that host is granted.
REQ-021 dev_req_o SHALL equal (|host_req_i) & ~full, where full means outstanding == MaxOutstanding.
REQ-022 A same-cycle response SHALL NOT lift the full condition; there is no combinational path from dev_rvalid_i to dev_req_o.
REQ-023 dev_addr/we/be/wdata SHALL be muxed from the winner, and SHALL be zero when dev_req_o=0.
REQ-024 host_gnt_o[winner] SHALL equal dev_req_o & dev_gnt_i; all other grant bits SHALL be 0.
REQ-025 On a grant the arbiter SHALL push the winner ID into the ID FIFO, set prio_q=(winner+1) mod NrHosts and clear the lock.
REQ-026 On dev_rvalid_i with FIFO non-empty, the arbiter SHALL pop the head and drive host_rvalid_o[head]=1 and host_err_o[head]=dev_err_i in the same cycle (zero latency).
REQ-027 host_rdata_o SHALL equal dev_rdata_i.
REQ-028 On dev_rvalid_i with FIFO empty, the response SHALL be dropped: no host_rvalid_o, spurious_o=1 for one cycle.
REQ-029 A simultaneous push and pop SHALL leave the count unchanged and keep response order FIFO.
REQ-030 A response to a grant SHALL be accepted no earlier than the cycle after that grant.
REQ-031 A host dropping its request while locked SHALL be a protocol violation; the design SHALL still release the lock when that host's request is low, to avoid deadlock.

Reset
REQ-032 On rst_i=1 at a clock edge, the block SHALL set prio_q=0, clear the lock, empty the FIFO and set outstanding_o=0.
REQ-033 During reset, host_gnt_o, host_rvalid_o, host_err_o, dev_req_o and spurious_o SHALL be 0 (all outputs zero).
REQ-034 Reset mid-transaction SHALL discard outstanding IDs; later responses SHALL be reported as spurious.

Structure
REQ-035 The ID FIFO SHALL be a sub-module bus_arb_id_fifo: depth MaxOutstanding, width $clog2(NrHosts), with push/pop/full/empty/count.
REQ-036 No shared package is required; the host-index width SHALL be a localparam computed from NrHosts.

Verification
REQ-037 Hosts 0 and 1 request continuously, dev_gnt_i=1, single-cycle responses: grants SHALL alternate 0,1,0,1 and responses SHALL route to the matching host.
REQ-038 Host 1 requests with dev_gnt_i=0 for 3 cycles, then host 0 also requests: the first grant SHALL go to host 1 (lock held).
REQ-039 MaxOutstanding=2, two grants with no response: dev_req_o SHALL be 0 and outstanding_o=2; after one rvalid, dev_req_o SHALL be 1 on the next cycle.
REQ-040 Grant to host 0 and an rvalid for an earlier host 1 transaction in the same cycle: host_rvalid_o=2'b10 and outstanding_o unchanged.
REQ-041 dev_rvalid_i=1 with no outstanding transaction: spurious_o SHALL pulse once and host_rvalid_o=0.
REQ-042 rst_i asserted with 2 outstanding, then a response arrives: outstanding_o=0, spurious_o=1, prio_q restarts at host 0.
